// File: rtl/y86_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : y86_mem_pkg
//  Description : Shared types, Y86 icode constants and the byte-order helper
//                for the sequenced Y86 data memory.
//  Revision    : 1.0 - initial release
// ============================================================================
package y86_mem_pkg;

  // Request sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } mem_state_e;

  // Y86 instruction codes that drive address/write selection upstream
  localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
  localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
  localparam logic [3:0] ICODE_CALL   = 4'h8;
  localparam logic [3:0] ICODE_RET    = 4'h9;
  localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
  localparam logic [3:0] ICODE_POPQ   = 4'hB;

  // Memory offset within a word -> data byte index (0 = least significant).
  // Big-endian keeps the most significant byte at the lowest address.
  function automatic int unsigned word_byte_to_data_idx(
    input int unsigned off,
    input int unsigned word_bytes,
    input bit          big_endian
  );
    if (big_endian) begin
      return word_bytes - 1 - off;
    end
    return off;
  endfunction

endpackage
`default_nettype wire

// File: rtl/y86_mem_lane_map.sv
`default_nettype none
// ============================================================================
//  Module      : y86_mem_lane_map
//  Description : Combinational lane mapper. For LANES consecutive word byte
//                offsets starting at base_i it gives the memory offset and the
//                data byte index selected by the configured byte order.
//  Revision    : 1.0 - initial release
// ============================================================================
module y86_mem_lane_map
  import y86_mem_pkg::*;
#(
  parameter int unsigned WORD_BYTES = 8,
  parameter int unsigned LANES      = 2,
  parameter int unsigned IDX_W      = 3,
  parameter bit          BIG_ENDIAN = 1'b1
) (
  input  logic [IDX_W-1:0]            base_i,
  output logic [LANES-1:0][IDX_W-1:0] off_o,
  output logic [LANES-1:0][IDX_W-1:0] sel_o
);

  generate
    for (genvar j = 0; j < LANES; j++) begin : g_lane
      assign off_o[j] = base_i + IDX_W'(j);
      assign sel_o[j] = IDX_W'(word_byte_to_data_idx(32'(off_o[j]), WORD_BYTES, BIG_ENDIAN));
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/y86_data_mem_seq.sv
`default_nettype none
// ============================================================================
//  Module      : y86_data_mem_seq
//  Description : Byte-addressed Y86 data memory accessed as WORD_BYTES words
//                over a valid/ready channel, moving BEAT_BYTES per cycle.
//                Out-of-range requests return an error without touching the
//                array. Includes a combinational debug word peek.
//  Revision    : 1.0 - initial release
// ============================================================================
module y86_data_mem_seq
  import y86_mem_pkg::*;
#(
  parameter int unsigned DEPTH_BYTES = 32,
  parameter int unsigned WORD_BYTES  = 8,
  parameter int unsigned BEAT_BYTES  = 2,
  parameter int unsigned ADDR_W      = 64,
  parameter bit          BIG_ENDIAN  = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_write_i,
  input  logic [ADDR_W-1:0]       req_addr_i,
  input  logic [8*WORD_BYTES-1:0] req_wdata_i,
  output logic                    resp_valid_o,
  output logic [8*WORD_BYTES-1:0] resp_rdata_o,
  output logic                    resp_error_o,
  input  logic [ADDR_W-1:0]       dbg_addr_i,
  output logic [8*WORD_BYTES-1:0] dbg_word_o
);

  localparam int unsigned NBEATS = WORD_BYTES / BEAT_BYTES;
  localparam int unsigned IDX_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int unsigned BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int unsigned MEM_AW = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
  localparam int unsigned DW     = 8 * WORD_BYTES;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEATS - 1);
  localparam logic [ADDR_W:0]   WORD_LEN  = (ADDR_W+1)'(WORD_BYTES);
  localparam logic [ADDR_W:0]   DEPTH_LEN = (ADDR_W+1)'(DEPTH_BYTES);

  mem_state_e          state_q, state_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [MEM_AW-1:0]   addr_q, addr_d;
  logic                write_q, write_d;
  logic [DW-1:0]       wdata_q, wdata_d;
  logic [DW-1:0]       asm_q, asm_d;
  logic [DW-1:0]       rdata_q, rdata_d;
  logic                error_q, error_d;
  logic                mem_we;

  logic [7:0]          mem_q [DEPTH_BYTES];

  logic [IDX_W-1:0]                 beat_base;
  logic [BEAT_BYTES-1:0][IDX_W-1:0] lane_off;
  logic [BEAT_BYTES-1:0][IDX_W-1:0] lane_sel;
  logic [BEAT_BYTES-1:0][MEM_AW-1:0] lane_addr;
  logic [WORD_BYTES-1:0][IDX_W-1:0] dbg_off;
  logic [WORD_BYTES-1:0][IDX_W-1:0] dbg_sel;

  logic [ADDR_W:0]     req_end;
  logic                req_oor;
  logic [ADDR_W:0]     dbg_end;
  logic                dbg_oor;
  logic [MEM_AW-1:0]   dbg_base;

  // Range checks carry one extra bit so a huge address cannot wrap into range
  assign req_end  = {1'b0, req_addr_i} + WORD_LEN;
  assign req_oor  = req_end > DEPTH_LEN;
  assign dbg_end  = {1'b0, dbg_addr_i} + WORD_LEN;
  assign dbg_oor  = dbg_end > DEPTH_LEN;
  assign dbg_base = dbg_addr_i[MEM_AW-1:0];

  assign beat_base = IDX_W'(beat_q) * IDX_W'(BEAT_BYTES);

  y86_mem_lane_map #(
    .WORD_BYTES (WORD_BYTES),
    .LANES      (BEAT_BYTES),
    .IDX_W      (IDX_W),
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_beat_map (
    .base_i (beat_base),
    .off_o  (lane_off),
    .sel_o  (lane_sel)
  );

  y86_mem_lane_map #(
    .WORD_BYTES (WORD_BYTES),
    .LANES      (WORD_BYTES),
    .IDX_W      (IDX_W),
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_dbg_map (
    .base_i ('0),
    .off_o  (dbg_off),
    .sel_o  (dbg_sel)
  );

  generate
    for (genvar j = 0; j < BEAT_BYTES; j++) begin : g_lane_addr
      assign lane_addr[j] = addr_q + MEM_AW'(lane_off[j]);
    end
  endgenerate

  assign req_ready_o  = (state_q == ST_IDLE);
  assign resp_valid_o = (state_q == ST_RESP);
  assign resp_rdata_o = rdata_q;
  assign resp_error_o = error_q;

  // Next-state, beat sequencing, load assembly and response capture
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
    asm_d   = asm_q;
    rdata_d = rdata_q;
    error_d = error_q;
    mem_we  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          addr_d  = req_addr_i[MEM_AW-1:0];
          write_d = req_write_i;
          wdata_d = req_wdata_i;
          if (req_oor) begin
            state_d = ST_RESP;
            error_d = 1'b1;
            rdata_d = '0;
          end else begin
            state_d = ST_BUSY;
            beat_d  = '0;
            asm_d   = '0;
          end
        end
      end
      ST_BUSY: begin
        if (write_q) begin
          mem_we = 1'b1;
        end else begin
          for (int j = 0; j < BEAT_BYTES; j++) begin
            asm_d[{lane_sel[j], 3'b000} +: 8] = mem_q[lane_addr[j]];
          end
        end
        if (beat_q == LAST_BEAT) begin
          state_d = ST_RESP;
          error_d = 1'b0;
          rdata_d = write_q ? '0 : asm_d;
        end else begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and datapath registers; the array itself is never reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      asm_q   <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      asm_q   <= asm_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
    end
  end

  // Store one beat of latched write data into the array
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int j = 0; j < BEAT_BYTES; j++) begin
        mem_q[lane_addr[j]] <= wdata_q[{lane_sel[j], 3'b000} +: 8];
      end
    end
  end

  // Debug peek: whole word at dbg_addr in the configured byte order
  always_comb begin
    dbg_word_o = '0;
    if (!dbg_oor) begin
      for (int k = 0; k < WORD_BYTES; k++) begin
        dbg_word_o[{dbg_sel[k], 3'b000} +: 8] = mem_q[dbg_base + MEM_AW'(dbg_off[k])];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_y86_data_mem_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_y86_data_mem_seq
//  Description : Directed self-checking bench for y86_data_mem_seq with a
//                big-endian and a little-endian instance on one clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_y86_data_mem_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_write;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;

  logic        be_valid, be_ready, be_rvalid, be_err;
  logic [63:0] be_rdata, be_dbg_addr, be_dbg;
  logic        le_valid, le_ready, le_rvalid, le_err;
  logic [63:0] le_rdata, le_dbg_addr, le_dbg;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  y86_data_mem_seq #(
    .DEPTH_BYTES (32), .WORD_BYTES (8), .BEAT_BYTES (2), .ADDR_W (64), .BIG_ENDIAN (1'b1)
  ) u_dut_be (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (be_valid),
    .req_ready_o  (be_ready),
    .req_write_i  (req_write),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .resp_valid_o (be_rvalid),
    .resp_rdata_o (be_rdata),
    .resp_error_o (be_err),
    .dbg_addr_i   (be_dbg_addr),
    .dbg_word_o   (be_dbg)
  );

  y86_data_mem_seq #(
    .DEPTH_BYTES (32), .WORD_BYTES (8), .BEAT_BYTES (2), .ADDR_W (64), .BIG_ENDIAN (1'b0)
  ) u_dut_le (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (le_valid),
    .req_ready_o  (le_ready),
    .req_write_i  (req_write),
    .req_addr_i   (req_addr),
    .req_wdata_i  (req_wdata),
    .resp_valid_o (le_rvalid),
    .resp_rdata_o (le_rdata),
    .resp_error_o (le_err),
    .dbg_addr_i   (le_dbg_addr),
    .dbg_word_o   (le_dbg)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One request on the chosen instance; lat counts cycles from the
  // acceptance cycle to the cycle showing resp_valid.
  task automatic do_req(input bit le, input bit wr, input logic [63:0] addr,
                        input logic [63:0] wdata, output logic [63:0] rdata,
                        output logic err, output int lat);
    int g;
    @(negedge clk);
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    if (le) le_valid = 1'b1; else be_valid = 1'b1;
    g = 0;
    while (!(le ? le_ready : be_ready) && g < 20) begin
      @(negedge clk);
      g++;
    end
    rdata = '0;
    err   = 1'b0;
    lat   = 0;
    if (!(le ? le_ready : be_ready)) begin
      check("ready_timeout", 64'd0, 64'd1);
      be_valid = 1'b0;
      le_valid = 1'b0;
      return;
    end
    @(negedge clk);
    be_valid = 1'b0;
    le_valid = 1'b0;
    lat = 1;
    while (!(le ? le_rvalid : be_rvalid) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!(le ? le_rvalid : be_rvalid)) begin
      check("resp_timeout", 64'd0, 64'd1);
      return;
    end
    rdata = le ? le_rdata : be_rdata;
    err   = le ? le_err : be_err;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] rd;
    logic        er;
    int          lat;
    int          acc_cyc [2];
    logic [63:0] resp_d [2];
    int          n_acc, n_resp, n_stray;

    rst_n = 1'b0;
    be_valid = 1'b0;  le_valid = 1'b0;
    req_write = 1'b0; req_addr = '0; req_wdata = '0;
    be_dbg_addr = '0; le_dbg_addr = '0;
    repeat (3) @(negedge clk);
    check("rst_ready",  64'(be_ready),  64'd1);
    check("rst_rvalid", 64'(be_rvalid), 64'd0);
    check("rst_rdata",  be_rdata,       64'd0);
    check("rst_error",  64'(be_err),    64'd0);
    rst_n = 1'b1;

    // Big-endian store/load at address 0
    do_req(0, 1, 64'd0, 64'h0102030405060708, rd, er, lat);
    check("st0_lat",   64'(lat), 64'd5);
    check("st0_err",   64'(er),  64'd0);
    check("st0_rdata", rd,       64'd0);
    do_req(0, 0, 64'd0, 64'd0, rd, er, lat);
    check("ld0_lat",   64'(lat), 64'd5);
    check("ld0_rdata", rd,       64'h0102030405060708);
    be_dbg_addr = 64'd0;
    #1;
    check("dbg0_byte", 64'(be_dbg[63:56]), 64'h01);
    check("dbg0_word", be_dbg,             64'h0102030405060708);

    // Last legal address, then first illegal one
    do_req(0, 1, 64'd24, 64'hDEADBEEFCAFEF00D, rd, er, lat);
    check("st24_err", 64'(er), 64'd0);
    do_req(0, 0, 64'd24, 64'd0, rd, er, lat);
    check("ld24_err",   64'(er), 64'd0);
    check("ld24_rdata", rd,      64'hDEADBEEFCAFEF00D);
    do_req(0, 1, 64'd25, 64'h1111111111111111, rd, er, lat);
    check("a25_lat",   64'(lat), 64'd1);
    check("a25_err",   64'(er),  64'd1);
    check("a25_rdata", rd,       64'd0);
    do_req(0, 0, 64'd24, 64'd0, rd, er, lat);
    check("ld24b_rdata", rd, 64'hDEADBEEFCAFEF00D);
    be_dbg_addr = 64'd25;
    #1;
    check("dbg25_oor", be_dbg, 64'd0);

    // Huge address must not wrap into range
    do_req(0, 0, 64'hFFFFFFFFFFFFFFFC, 64'd0, rd, er, lat);
    check("wrap_err",   64'(er), 64'd1);
    check("wrap_rdata", rd,      64'd0);

    // Little-endian instance
    do_req(1, 1, 64'd8, 64'h1122334455667788, rd, er, lat);
    check("le_st_err", 64'(er), 64'd0);
    le_dbg_addr = 64'd8;
    #1;
    check("le_dbg_byte", 64'(le_dbg[7:0]), 64'h88);
    do_req(1, 0, 64'd8, 64'd0, rd, er, lat);
    check("le_ld_lat",   64'(lat), 64'd5);
    check("le_ld_rdata", rd,       64'h1122334455667788);

    // Reset during beat 1 of a store over zeroed bytes
    do_req(0, 1, 64'd16, 64'd0, rd, er, lat);
    @(negedge clk);
    req_write = 1'b1; req_addr = 64'd16; req_wdata = 64'hAAAAAAAAAAAAAAAA;
    be_valid = 1'b1;
    check("rb_ready_pre", 64'(be_ready), 64'd1);
    @(negedge clk);           // beat 0 in progress
    be_valid = 1'b0;
    @(negedge clk);           // beat 1 in progress
    rst_n = 1'b0;
    #1;
    check("rb_ready",  64'(be_ready),  64'd1);
    check("rb_rvalid", 64'(be_rvalid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n_stray = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (be_rvalid) n_stray++;
    end
    check("rb_no_resp", 64'(n_stray), 64'd0);
    do_req(0, 0, 64'd16, 64'd0, rd, er, lat);
    check("rb_ld_rdata", rd, 64'hAAAA000000000000);

    // Held req_valid with changing address while busy
    @(negedge clk);
    n_acc = 0; n_resp = 0;
    acc_cyc[0] = 0; acc_cyc[1] = 0;
    resp_d[0] = '0; resp_d[1] = '0;
    for (int k = 0; k < 16; k++) begin
      req_write = 1'b0;
      req_addr  = (k == 0) ? 64'd0 : ((k < 6) ? 64'd8 : 64'd24);
      be_valid  = (n_acc < 2);
      if (be_valid && be_ready) begin
        acc_cyc[n_acc] = k;
        n_acc++;
      end
      if (be_rvalid && n_resp < 2) begin
        resp_d[n_resp] = be_rdata;
        n_resp++;
      end
      @(negedge clk);
    end
    be_valid = 1'b0;
    check("hold_nacc",    64'(n_acc),                   64'd2);
    check("hold_spacing", 64'(acc_cyc[1] - acc_cyc[0]), 64'd6);
    check("hold_nresp",   64'(n_resp),                  64'd2);
    check("hold_resp0",   resp_d[0],                    64'h0102030405060708);
    check("hold_resp1",   resp_d[1],                    64'hDEADBEEFCAFEF00D);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/y86_data_mem_seq.md
Name: y86_data_mem_seq

Overview:
Clocked, parametrised successor to the combinational data memory of the Y86 sequential core. It is a byte-addressed store accessed as WORD_BYTES-wide words through a valid/ready request channel. The array port is BEAT_BYTES wide, so one word takes several beats, sequenced by an FSM. It reports out-of-range accesses cleanly and has a selectable byte order. It sits behind the memory stage: the stage drives address, write and write data, and waits for resp_valid.

Parameters:
DEPTH_BYTES, 32, number of bytes in the array.
WORD_BYTES, 8, bytes per access (Y86 quad word).
BEAT_BYTES, 2, bytes moved per cycle; must divide WORD_BYTES; NBEATS = WORD_BYTES/BEAT_BYTES.
ADDR_W, 64, request address width.
BIG_ENDIAN, 1, 1 means mem[addr] holds the most significant byte; 0 means mem[addr] holds the least significant byte.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous, active-low reset.
req_valid  in  1  request present.
req_ready  out  1  block can accept a request; high only in IDLE.
req_write  in  1  1 = store, 0 = load.
req_addr  in  ADDR_W  byte address of the word.
req_wdata  in  8*WORD_BYTES  store data.
resp_valid  out  1  one-cycle response pulse.
resp_rdata  out  8*WORD_BYTES  load data; 0 for stores and errors.
resp_error  out  1  access out of range; valid with resp_valid.
dbg_addr  in  ADDR_W  debug peek address.
dbg_word  out  8*WORD_BYTES  combinational word at dbg_addr, same byte order; 0 if out of range.

Behaviour:
- Reset (async assert, sync deassert by system): state IDLE, beat counter 0, req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0. Array contents are not reset.
- States: IDLE, BUSY, RESP.
- IDLE: a handshake occurs when req_valid and req_ready are both high. The block latches addr, write and wdata.
  - Range check uses ADDR_W+1-bit arithmetic, so there is no wrap. If req_addr + WORD_BYTES > DEPTH_BYTES, the block goes to RESP with error=1, rdata=0, and the array is untouched.
  - Otherwise the block goes to BUSY with beat=0.
- BUSY, each cycle:
  - The block moves beat bytes at word byte offsets beat*BEAT_BYTES .. beat*BEAT_BYTES+BEAT_BYTES-1.
  - Store: writes the corresponding slice of the latched wdata, mapped per BIG_ENDIAN, into the array.
  - Load: writes the array bytes into the matching slice of an internal assembly register.
  - On beat == NBEATS-1 the block goes to RESP; otherwise beat increments.
- RESP: resp_valid=1 for exactly one cycle. rdata is the assembled word for loads and 0 for stores; error is as latched. The next state is IDLE.
- Outputs in RESP are registered. resp_rdata and resp_error hold their value until the next RESP. resp_valid is 0 outside RESP.
- Latency from accepted request to resp_valid: NBEATS+1 cycles for in-range accesses, 1 cycle for errors.
- Throughput: one request per NBEATS+2 cycles. There is no response backpressure.
- req_* inputs are ignored while req_ready=0.
- Reset mid-BUSY: returns to IDLE with no response. Bytes already stored stay written (no rollback).
- Last legal address is DEPTH_BYTES-WORD_BYTES, which must succeed. The next address must error.
- Load-after-store to the same address returns the new data, because accesses are serialised.
- dbg_word is purely combinational. It reflects writes from the previous edge.

Decomposition:
- Package y86_mem_pkg holds:
  - the state enum (IDLE, BUSY, RESP);
  - Y86 icode constants used by the address/write-select logic upstream (RMMOVQ=4, MRMOVQ=5, CALL=8, RET=9, PUSHQ=A, POPQ=B);
  - a function mapping a word byte index to a memory offset per BIG_ENDIAN.
- One sub-module, y86_mem_lane_map: combinational. It maps (beat, BIG_ENDIAN) to array offsets and data slices, and is reused by the BUSY datapath and the dbg_word path.

Test Plan:
- Parameters DEPTH_BYTES=32, WORD_BYTES=8, BEAT_BYTES=2, BIG_ENDIAN=1.
- Store addr 0, data 0x0102030405060708, then load addr 0 -> first resp_valid 5 cycles after acceptance with error=0 and rdata=0; load rdata=0x0102030405060708; dbg_addr=0 shows mem[0]=0x01.
- Store addr 24 (last legal), data 0xDEADBEEFCAFEF00D, then load 24 -> error=0, rdata=0xDEADBEEFCAFEF00D. Request addr 25 -> resp_valid 1 cycle after acceptance, error=1, rdata=0, and the load at 24 is unchanged.
- Request addr 0xFFFFFFFFFFFFFFFC -> error=1 (no wrap false-pass).
- BIG_ENDIAN=0 build: store 0x1122334455667788 at 8 -> dbg byte at 8 is 0x88; load 8 returns 0x1122334455667788.
- Assert rst_n low during BUSY beat 1 of a store of 0xAAAA..AA over 0x00 at addr 16 -> no resp_valid, req_ready=1 immediately; load 16 returns 0xAAAA000000000000.
- Hold req_valid high with changing addr while req_ready=0 -> only the first request is serviced; back-to-back requests are spaced NBEATS+2=6 cycles apart.
